mem_arbiter: RTL

Shares one single-port memory between the pipeline's instruction-fetch port and data-memory port, serialising accesses and returning per-port ready pulses. Sits between the datapath (fetch and mem stages) and the unified memory; its stall outputs feed the hazard unit so fetch and mem stages freeze while their access is outstanding. Data port has fixed priority by default; round-robin is a build option.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Grant encoding is one bit so it doubles as the round-robin last-grant pointer.
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/mem stages, the arbiter and the unified memory.
// slave = arbiter view, master = environment (requesters + memory) view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_ready;
    logic              inst_stall;

    logic              data_req;
    logic              data_we;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_ready;
    logic              data_stall;

    logic              mem_req;
    logic              mem_we;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_wstrb, data_addr, data_wdata,
        input  mem_rdata, mem_ack,
        output inst_rdata, inst_ready, inst_stall,
        output data_rdata, data_ready, data_stall,
        output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_wstrb, data_addr, data_wdata,
        output mem_rdata, mem_ack,
        input  inst_rdata, inst_ready, inst_stall,
        input  data_rdata, data_ready, data_stall,
        input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant select between fetch and data requests.
// ARB_RR_EN defined: alternate on contention using the last-grant pointer; else data wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_inst_req,
    input  logic i_data_req,
    input  logic i_last_gnt,
    output logic o_valid_c,
    output logic o_gnt_c
);

    assign o_valid_c = i_inst_req | i_data_req;

`ifdef ARB_RR_EN
    always_comb begin
        o_gnt_c = GNT_I;
        if (i_inst_req && i_data_req) begin
            o_gnt_c = (i_last_gnt == GNT_D) ? GNT_I : GNT_D;
        end else if (i_data_req) begin
            o_gnt_c = GNT_D;
        end
    end
`else
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = i_last_gnt;
    assign o_gnt_c           = i_data_req ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one single-port memory.
// Build option ARB_RR_EN selects round-robin instead of fixed data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e        r_state,      w_state_nxt;
    logic              r_mem_req,    w_mem_req_nxt;
    logic              r_mem_we,     w_mem_we_nxt;
    logic [STRB_W-1:0] r_mem_wstrb,  w_mem_wstrb_nxt;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_inst_rdata, w_inst_rdata_nxt;
    logic [DATA_W-1:0] r_data_rdata, w_data_rdata_nxt;
    logic              r_inst_ready, w_inst_ready_nxt;
    logic              r_data_ready, w_data_ready_nxt;
    logic              r_last_gnt,   w_last_gnt_nxt;

    logic              w_gnt_valid;
    logic              w_gnt;

    arb_pick u_pick (
        .i_inst_req (bus.inst_req),
        .i_data_req (bus.data_req),
        .i_last_gnt (r_last_gnt),
        .o_valid_c  (w_gnt_valid),
        .o_gnt_c    (w_gnt)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_req_nxt    = 1'b0;
        w_mem_we_nxt     = r_mem_we;
        w_mem_wstrb_nxt  = r_mem_wstrb;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_inst_rdata_nxt = r_inst_rdata;
        w_data_rdata_nxt = r_data_rdata;
        w_inst_ready_nxt = 1'b0;
        w_data_ready_nxt = 1'b0;
        w_last_gnt_nxt   = r_last_gnt;

        unique case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_mem_req_nxt  = 1'b1;
                    w_last_gnt_nxt = w_gnt;
                    if (w_gnt == GNT_D) begin
                        w_state_nxt     = BUSY_D;
                        w_mem_we_nxt    = bus.data_we;
                        w_mem_wstrb_nxt = bus.data_wstrb;
                        w_mem_addr_nxt  = bus.data_addr;
                        w_mem_wdata_nxt = bus.data_wdata;
                    end else begin
                        w_state_nxt     = BUSY_I;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_wstrb_nxt = '0;
                        w_mem_addr_nxt  = bus.inst_addr;
                        w_mem_wdata_nxt = '0;
                    end
                end
            end
            BUSY_I: begin
                if (bus.mem_ack) begin
                    w_state_nxt      = RESP_I;
                    w_inst_rdata_nxt = bus.mem_rdata;
                    w_inst_ready_nxt = 1'b1;
                end else begin
                    w_mem_req_nxt = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    w_state_nxt      = RESP_D;
                    w_data_rdata_nxt = bus.mem_rdata;
                    w_data_ready_nxt = 1'b1;
                end else begin
                    w_mem_req_nxt = 1'b1;
                end
            end
            RESP_I, RESP_D: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Reset abandons any outstanding access; the memory sees mem_req withdrawn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wstrb  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_last_gnt   <= GNT_I;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_wstrb  <= w_mem_wstrb_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_inst_rdata <= w_inst_rdata_nxt;
            r_data_rdata <= w_data_rdata_nxt;
            r_inst_ready <= w_inst_ready_nxt;
            r_data_ready <= w_data_ready_nxt;
            r_last_gnt   <= w_last_gnt_nxt;
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wstrb  = r_mem_wstrb;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.inst_rdata = r_inst_rdata;
    assign bus.data_rdata = r_data_rdata;
    assign bus.inst_ready = r_inst_ready;
    assign bus.data_ready = r_data_ready;

    // Stalls are the only outputs allowed to follow the request inputs directly.
    assign bus.inst_stall = bus.inst_req & ~r_inst_ready;
    assign bus.data_stall = bus.data_req & ~r_data_ready;

endmodule
